pc_branch_unit: RTL

- Parametrised program-counter unit: owns the architectural PC register and resolves conditional branches each cycle.
- Branch modes: PC-relative immediate (B) and register-indirect (BR).
- Provides stall hold and a HALT state.
- Sits in the fetch stage; drives the instruction-memory address and consumes flags from the flag register plus the decoded branch fields.

---
 rtl/pc_branch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch-stage program-counter register with conditional
// branch resolution (PC-relative immediate B, register-indirect BR),
// stall hold and a sticky HALTED state.
//
// Optional build macro PC_BRANCH_STATS_EN adds saturating branch_count and
// taken_count outputs. Without the macro those ports do not exist.
//
// The FSM state is observable on the halted output, which is registered
// from the same next-state value as the state register.
module pc_branch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 OFFSET_W = 9,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 INC      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                halt,
    input  logic                branch_en,
    input  logic                branch_reg,
    input  logic [2:0]          ccc,
    input  logic [2:0]          flags,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [ADDR_W-1:0]   reg_target,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus_inc,
    output logic [ADDR_W-1:0]   next_pc,
    output logic                taken,
`ifdef PC_BRANCH_STATS_EN
    output logic [15:0]         branch_count,
    output logic [15:0]         taken_count,
`endif
    output logic                halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic                cond_ok;
    logic                branch_req;
    logic [ADDR_W-1:0]   offset_ext;
    logic [ADDR_W-1:0]   imm_target;

    // Flag bits: Z is flags[2], V is flags[1], N is flags[0].
    logic flag_z;
    logic flag_v;
    logic flag_n;
    assign flag_z = flags[2];
    assign flag_v = flags[1];
    assign flag_n = flags[0];

    // Condition-code decode against the current flags.
    always_comb begin
        cond_ok = 1'b0;
        case (ccc)
            3'b000:  cond_ok = ~flag_z;
            3'b001:  cond_ok = flag_z;
            3'b010:  cond_ok = ~(flag_z | flag_n);
            3'b011:  cond_ok = flag_n;
            3'b100:  cond_ok = flag_z | ~flag_n;
            3'b101:  cond_ok = flag_z | flag_n;
            3'b110:  cond_ok = flag_v;
            default: cond_ok = 1'b1;
        endcase
    end

    // Word offset is sign-extended to the address width and scaled to bytes;
    // all sums wrap modulo 2^ADDR_W.
    assign offset_ext  = {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    assign pc_plus_inc = pc + ADDR_W'(INC);
    assign imm_target  = pc_plus_inc + (offset_ext << 1);

    // A branch instruction is only considered while running and not held.
    assign branch_req = (state == ST_RUN) & ~stall & ~halt & (branch_en | branch_reg);
    assign taken      = branch_req & cond_ok;

    // Next-PC selection and next-state; BR wins over B when both are set.
    always_comb begin
        next_pc    = pc_plus_inc;
        state_next = state;
        if ((state == ST_HALTED) || stall) begin
            next_pc = pc;
        end else if (halt) begin
            next_pc    = pc;
            state_next = ST_HALTED;
        end else if (taken && branch_reg) begin
            next_pc = reg_target;
        end else if (taken && branch_en) begin
            next_pc = imm_target;
        end
    end

    // PC register, FSM state and registered halted flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            pc     <= next_pc;
            state  <= state_next;
            halted <= (state_next == ST_HALTED);
        end
    end

`ifdef PC_BRANCH_STATS_EN
    // Saturating counters of considered branches and taken branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            if (branch_req && (branch_count != 16'hFFFF)) begin
                branch_count <= branch_count + 16'd1;
            end
            if (taken && (taken_count != 16'hFFFF)) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end
`endif

endmodule
